button_bank: RTL and testbench
==============================

# button_bank

Parametrised multi-channel push-button front end. It sits between the raw board pins and the control logic. Per channel it:
- synchronises the raw input;
- debounces it with a consecutive-sample counter;
- classifies each press as short or long, with optional auto-repeat while held.

Each channel presents a clean level plus single-cycle event pulses to downstream FSMs.

## Interface
- N_BUTTONS, 5: number of independent channels (≥1)
- DEBOUNCE_CYCLES, 50: consecutive disagreeing samples required to flip the debounced level (≥1)
- LONG_CYCLES, 1000: debounced-high cycles before a press counts as long (≥1)
- REPEAT_CYCLES, 0: auto-repeat period after long detection; 0 disables repeat
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- button  in  N_BUTTONS  raw asynchronous pin levels, 1 = pressed
- state  out  N_BUTTONS  debounced level per channel
- pulse  out  N_BUTTONS  1-cycle strobe on debounced rising edge (press)
- release_pulse  out  N_BUTTONS  1-cycle strobe on debounced falling edge
- short_pulse  out  N_BUTTONS  1-cycle strobe on release of a press shorter than LONG_CYCLES
- long_pulse  out  N_BUTTONS  1-cycle strobe when a held press reaches LONG_CYCLES
- repeat_pulse  out  N_BUTTONS  1-cycle strobe every REPEAT_CYCLES after long_pulse while still held

## Operation
- Channels are fully independent. Simultaneous activity on any subset behaves exactly as each channel alone.
- Synchroniser: 2 flops per channel, reset to 0. Output is sync.
- Debounce:
  - counter clears whenever sync == state;
  - increments on each cycle sync != state;
  - on the DEBOUNCE_CYCLES-th consecutive disagreeing sample, state flips and the counter clears.
  - Any agreeing sample in between restarts the count. Glitches shorter than DEBOUNCE_CYCLES never reach state.
- Press classifier FSM per channel: IDLE, PRESSED, LONG.
  - IDLE → PRESSED on state rise; pulse=1. Hold counter clears.
  - PRESSED: hold counter increments each cycle.
    - When it reaches LONG_CYCLES-1 with state still 1: → LONG, long_pulse=1, repeat counter clears.
    - On state fall: → IDLE, release_pulse=1, short_pulse=1.
  - LONG: if REPEAT_CYCLES>0, the repeat counter counts 0..REPEAT_CYCLES-1, then repeat_pulse=1 and it wraps to 0.
    - On state fall: → IDLE, release_pulse=1, no short_pulse, no repeat_pulse that cycle.
- Counter widths: $clog2(X+1) of the respective parameter. The hold counter never exceeds LONG_CYCLES-1; no wrap.
- Reset values: all outputs 0, FSM IDLE, all counters 0, synchronisers 0.
- Reset asserted mid-press aborts silently: no release or short pulse.
- A button held through reset deassertion is seen as a fresh press and produces pulse after the normal latency.

## Timing
- All outputs are registered. Pulses are exactly 1 cycle wide.
- Press latency: raw edge stable from before rising edge k → sync high after edge k+1 → state and pulse high after edge k+1+DEBOUNCE_CYCLES. Same latency for release.
- pulse and state rise in the same cycle; release_pulse (and short_pulse if applicable) coincide with the state fall.
- long_pulse occurs exactly LONG_CYCLES cycles after pulse.
- First repeat_pulse occurs REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES.
- A press released on the same edge the hold counter would hit LONG_CYCLES-1 is a short press; release wins.
- DEBOUNCE_CYCLES=1: state follows sync with 1-cycle delay, no filtering.

## Structure
- Package button_pkg holds:
  - typedef enum {IDLE, PRESSED, LONG} press_state_t;
  - counter-width helper functions.
- Sub-module button_channel:
  - one synchroniser + debouncer + FSM, same parameters;
  - button_bank is a generate loop of N_BUTTONS instances, outputs concatenated bit-per-channel.
- Parameter sanity checks sit in an initial block: $error if DEBOUNCE_CYCLES<1 or LONG_CYCLES<1.

## Test plan
- Bouncy short press, D=50, L=1000, 10 ns clk: glitches 1–25 ns then steady high 1 µs then low → exactly one pulse, one release_pulse, one short_pulse, no long_pulse. state high for ≈1 µs, latency 51–52 cycles after last bounce.
- Long press, L=100, R=0: hold 300 cycles → long_pulse exactly 100 cycles after pulse. Release gives release_pulse only.
- Auto-repeat, L=100, R=20: hold 200 cycles → long_pulse at +100, repeat_pulse at +120, +140, +160… Stops on release.
- Multi-channel, N=5: channel 0 short press overlapping channel 3 long press, channel 2 bouncing below debounce threshold → independent correct pulses on 0 and 3; nothing on channel 2.
- Release boundary: release timed so state falls on the cycle the hold count reaches LONG_CYCLES-1 → short_pulse, no long_pulse.
- Reset mid-press: assert rst_n=0 during PRESSED → all outputs 0 immediately, no release pulse. Button still held at deassert → pulse at DEBOUNCE_CYCLES+2 cycles.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and counter sizing helpers for the push-button front end.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } press_state_t;

    // Width able to hold 0..max_count; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Terminal value of a counter that runs 0..period-1 (0 when period is 0).
    function automatic int last_count(input int period);
        return (period < 1) ? 0 : period - 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, consecutive-sample debouncer
// and a short/long/repeat press classifier with registered strobes.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int LONG_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         button,
    output logic         state,
    output logic         pulse,
    output logic         release_pulse,
    output logic         short_pulse,
    output logic         long_pulse,
    output logic         repeat_pulse,
    output press_state_t fsm_state
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DB_LAST   = DW'(last_count(DEBOUNCE_CYCLES));
    localparam logic [HW-1:0] HOLD_LAST = HW'(last_count(LONG_CYCLES));
    localparam logic [RW-1:0] REP_LAST  = RW'(last_count(REPEAT_CYCLES));

    logic          sync_meta;
    logic          sync;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          flip;
    logic          rise;
    logic          fall;

    // The classifier reacts on the same edge the debounced level flips, so
    // pulse/state and release_pulse/state-fall land in the same cycle.
    assign flip = (sync != state) && (db_cnt == DB_LAST);
    assign rise = flip && !state;
    assign fall = flip && state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state     <= 1'b0;
            db_cnt    <= '0;
        end else begin
            sync_meta <= button;
            sync      <= sync_meta;
            if (sync == state) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                state  <= ~state;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state     <= IDLE;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            pulse         <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            pulse         <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (rise) begin
                        fsm_state <= PRESSED;
                        pulse     <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                PRESSED: begin
                    // Release takes priority over reaching the long threshold.
                    if (fall) begin
                        fsm_state     <= IDLE;
                        release_pulse <= 1'b1;
                        short_pulse   <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        fsm_state  <= LONG;
                        long_pulse <= 1'b1;
                        rep_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                LONG: begin
                    if (fall) begin
                        fsm_state     <= IDLE;
                        release_pulse <= 1'b1;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (rep_cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
                    end
                end
                default: begin
                    fsm_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_bank.sv
// Bank of independent push-button channels; every output is one bit per channel.
module button_bank
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 5,
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int LONG_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] state,
    output logic [N_BUTTONS-1:0] pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] short_pulse,
    output logic [N_BUTTONS-1:0] long_pulse,
    output logic [N_BUTTONS-1:0] repeat_pulse
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_bank: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("button_bank: LONG_CYCLES must be >= 1");
    end

    // Per-channel classifier state, kept as a named array for probing.
    press_state_t press_state_unused [N_BUTTONS];

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .button       (button[i]),
            .state        (state[i]),
            .pulse        (pulse[i]),
            .release_pulse(release_pulse[i]),
            .short_pulse  (short_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .repeat_pulse (repeat_pulse[i]),
            .fsm_state    (press_state_unused[i])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: expected strobes are queued when a
// press is driven and matched against the outputs every cycle.
module tb_button_bank;

    localparam int N_A = 5, D_A = 6, L_A = 40, R_A = 8;
    localparam int N_B = 2, D_B = 1, L_B = 5,  R_B = 0;
    localparam int CH_B = 8;
    localparam int W = 32;
    localparam int K_PRESS = 0, K_REL = 1, K_SHORT = 2, K_LONG = 3, K_REP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N_A-1:0] btn_a = '0;
    logic [N_A-1:0] st_a, pu_a, rl_a, sh_a, lg_a, rp_a;
    logic [N_B-1:0] btn_b = '0;
    logic [N_B-1:0] st_b, pu_b, rl_b, sh_b, lg_b, rp_b;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rel_at[10];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    button_bank #(
        .N_BUTTONS(N_A), .DEBOUNCE_CYCLES(D_A), .LONG_CYCLES(L_A), .REPEAT_CYCLES(R_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .button(btn_a), .state(st_a), .pulse(pu_a),
        .release_pulse(rl_a), .short_pulse(sh_a), .long_pulse(lg_a), .repeat_pulse(rp_a)
    );

    button_bank #(
        .N_BUTTONS(N_B), .DEBOUNCE_CYCLES(D_B), .LONG_CYCLES(L_B), .REPEAT_CYCLES(R_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .button(btn_b), .state(st_b), .pulse(pu_b),
        .release_pulse(rl_b), .short_pulse(sh_b), .long_pulse(lg_b), .repeat_pulse(rp_b)
    );

    // ---------------- helpers ----------------
    function automatic int d_of(input int ch); return (ch >= CH_B) ? D_B : D_A; endfunction
    function automatic int l_of(input int ch); return (ch >= CH_B) ? L_B : L_A; endfunction
    function automatic int r_of(input int ch); return (ch >= CH_B) ? R_B : R_A; endfunction

    function automatic logic [W-1:0] mk(input int t, input int ch, input int k);
        return W'((t << 7) | (ch << 3) | k);
    endfunction

    task automatic set_btn(input int ch, input logic v);
        if (ch >= CH_B) btn_b[ch-CH_B] = v;
        else btn_a[ch] = v;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_bits(input int ch, input logic [4:0] ev);
        for (int k = 0; k < 5; k++) begin
            if (ev[k]) begin
                logic [W-1:0] e;
                int idx;
                logic found;
                e = mk(cyc, ch, k);
                idx = -1;
                foreach (exp_q[i]) if (idx < 0 && exp_q[i] === e) idx = i;
                found = (idx >= 0);
                checks++;
                assert (found === 1'b1) else begin
                    failures++;
                    $error("FAIL strobe ch=%0d kind=%0d cyc=%0d observed=1 expected=0", ch, k, cyc);
                end
                if (found) exp_q.delete(idx);
            end
        end
    endtask

    task automatic monitor();
        for (int ch = 0; ch < N_A; ch++)
            check_bits(ch, {rp_a[ch], lg_a[ch], sh_a[ch], rl_a[ch], pu_a[ch]});
        for (int ch = 0; ch < N_B; ch++)
            check_bits(CH_B + ch, {rp_b[ch], lg_b[ch], sh_b[ch], rl_b[ch], pu_b[ch]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
        for (int ch = 0; ch < 10; ch++) begin
            if (rel_at[ch] == cyc) begin
                set_btn(ch, 1'b0);
                rel_at[ch] = -1;
            end
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // Press held clean for 'hold' cycles (hold >= debounce length); queues
    // every strobe the press must produce and returns the pulse cycle.
    task automatic press_start(input int ch, input int hold, output int p);
        int f, l, r;
        set_btn(ch, 1'b1);
        p = cyc + 2 + d_of(ch);
        f = p + hold;
        l = l_of(ch);
        r = r_of(ch);
        exp_q.push_back(mk(p, ch, K_PRESS));
        exp_q.push_back(mk(f, ch, K_REL));
        if (hold <= l) begin
            exp_q.push_back(mk(f, ch, K_SHORT));
        end else begin
            exp_q.push_back(mk(p + l, ch, K_LONG));
            if (r > 0)
                for (int t = p + l + r; t < f; t += r) exp_q.push_back(mk(t, ch, K_REP));
        end
        rel_at[ch] = cyc + hold;
    endtask

    task automatic glitch(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            set_btn(ch, 1'b1);
            repeat ($urandom_range(1, d_of(ch) - 1)) tick();
            set_btn(ch, 1'b0);
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int p, p2, h, ch;
        for (int i = 0; i < 10; i++) rel_at[i] = -1;

        // reset state, with buttons high while reset is held
        repeat (2) tick();
        btn_a = '1;
        btn_b = '1;
        repeat (4) tick();
        check_val("reset_a", {2'b0, st_a, pu_a, rl_a, sh_a, lg_a, rp_a}, 32'd0);
        check_val("reset_b", {20'b0, st_b, pu_b, rl_b, sh_b, lg_b, rp_b}, 32'd0);
        btn_a = '0;
        btn_b = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // bouncy short press on channel 0 with a sub-threshold dropout while held
        glitch(0, 4);
        press_start(0, 25, p);
        wait_until(p - 1);
        check_val("bounce_state_before", 32'(st_a[0]), 32'd0);
        tick();
        check_val("bounce_state_rise", 32'(st_a[0]), 32'd1);
        repeat (3) tick();
        btn_a[0] = 1'b0;
        repeat (3) tick();
        btn_a[0] = 1'b1;
        repeat (6) tick();
        check_val("dropout_state_held", 32'(st_a[0]), 32'd1);
        repeat (30) tick();
        check_val("bounce_state_after", 32'(st_a[0]), 32'd0);

        // long presses with repeat; release exactly on a repeat slot, then past it
        press_start(1, L_A + 2 * R_A, p);
        repeat (L_A + 2 * R_A + 12) tick();
        press_start(1, 70, p);
        wait_until(p + 50);
        check_val("long_state_held", 32'(st_a[1]), 32'd1);
        repeat (40) tick();

        // release boundary around the long threshold
        press_start(2, L_A, p);
        repeat (L_A + 12) tick();
        press_start(2, L_A + 1, p);
        repeat (L_A + 13) tick();
        press_start(2, L_A - 1, p);
        repeat (L_A + 11) tick();

        // overlapping channels: 3 long, 0 and 4 short together, 2 only glitching
        press_start(3, 60, p);
        repeat (3) tick();
        press_start(0, 12, p2);
        press_start(4, 12, p2);
        glitch(2, 6);
        check_val("glitch_state_ch2", 32'(st_a[2]), 32'd0);
        repeat (80) tick();

        // second bank: single-sample debounce, no repeat
        press_start(CH_B, 12, p);
        press_start(CH_B + 1, 1, p2);
        wait_until(p);
        check_val("d1_state_rise", {30'b0, st_b}, 32'd3);
        repeat (8) tick();
        press_start(CH_B + 1, L_B, p2);
        repeat (20) tick();

        // random single presses on the main bank
        for (int i = 0; i < 6; i++) begin
            ch = int'($urandom_range(0, N_A - 1));
            h = int'($urandom_range(D_A, 70));
            press_start(ch, h, p);
            repeat (h + D_A + 6) tick();
        end

        // reset in the middle of a press, button still held at deassertion
        press_start(1, 200, p);
        wait_until(p + 10);
        check_val("pre_reset_state", 32'(st_a[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("reset_async_a", {2'b0, st_a, pu_a, rl_a, sh_a, lg_a, rp_a}, 32'd0);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (int'(exp_q[i] >> 7) > cyc) exp_q.delete(i);
        rel_at[1] = -1;
        repeat (4) tick();
        rst_n = 1'b1;
        press_start(1, 30, p);
        check_val("repress_latency", p - cyc, D_A + 2);
        wait_until(p - 1);
        check_val("repress_state_low", 32'(st_a[1]), 32'd0);
        repeat (50) tick();

        // drain and final checks
        repeat (20) tick();
        check_val("final_state_a", 32'(st_a), 32'd0);
        check_val("final_state_b", 32'(st_b), 32'd0);
        checks++;
        assert (exp_q.size() === 0) else begin
            failures++;
            $error("FAIL pending_strobes observed=%0d expected=0", exp_q.size());
        end
        foreach (exp_q[i])
            $display("  never seen: ch=%0d kind=%0d cyc=%0d", (exp_q[i] >> 3) & 15, exp_q[i] & 7, exp_q[i] >> 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
